// File: rtl/game_score_ctrl.sv
// Score controller for a 3-digit FND display.
// It arbitrates add and subtract requests and keeps a saturating binary score.
// The score is converted to BCD by repeated subtraction, so the datapath has no
// divider and no multiplier. The digit outputs update only when a conversion
// has finished.
//
// state  | meaning
// IDLE   | waiting; accepts one request per visit
// CONV_H | peel off hundreds (work -= 100, H += 1)
// CONV_T | peel off tens (work -= 10, T += 1)
// DONE   | publish H/T/ones to the digit registers
module game_score_ctrl #(
    parameter int MAX_SCORE = 999,
    parameter int VAL_W     = 4
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic             i_Clr,
    input  logic             i_Add_Req,
    input  logic [VAL_W-1:0] i_Add_Val,
    input  logic             i_Sub_Req,
    input  logic [VAL_W-1:0] i_Sub_Val,
    output logic             o_Add_Ack,
    output logic             o_Sub_Ack,
    output logic [9:0]       o_Score,
    output logic [3:0]       o_Score0,
    output logic [3:0]       o_Score1,
    output logic [3:0]       o_Score2,
    output logic             o_Busy,
    output logic             o_Upd
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CONV_H = 2'd1;
    localparam logic [1:0] S_CONV_T = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [9:0] MAX_S = 10'(MAX_SCORE);

    logic [1:0]  r_State;
    logic [1:0]  w_Next;
    logic        r_Rr_Sub;     // 1: subtract wins the next contention
    logic [9:0]  r_Score;
    logic [9:0]  r_Work;
    logic [3:0]  r_H;
    logic [3:0]  r_T;
    logic [3:0]  r_D0;
    logic [3:0]  r_D1;
    logic [3:0]  r_D2;
    logic        r_Add_Ack;
    logic        r_Sub_Ack;
    logic        r_Busy;
    logic        r_Upd;

    logic        w_Idle_Ok;
    logic        w_Grant_Add;
    logic        w_Grant_Sub;
    logic [10:0] w_Sum;
    logic [10:0] w_Sub_Ext;
    logic [9:0]  w_Add_Res;
    logic [9:0]  w_Sub_Res;

    // Arbitration and saturating arithmetic for the request that may be accepted
    assign w_Idle_Ok   = (r_State == S_IDLE) && !i_Clr;
    assign w_Grant_Add = w_Idle_Ok && i_Add_Req && (!i_Sub_Req || !r_Rr_Sub);
    assign w_Grant_Sub = w_Idle_Ok && i_Sub_Req && (!i_Add_Req ||  r_Rr_Sub);
    assign w_Sum       = {1'b0, r_Score} + 11'(i_Add_Val);
    assign w_Sub_Ext   = {1'b0, r_Score} - 11'(i_Sub_Val);
    assign w_Add_Res   = (w_Sum > {1'b0, MAX_S}) ? MAX_S : w_Sum[9:0];
    assign w_Sub_Res   = w_Sub_Ext[10] ? 10'd0 : w_Sub_Ext[9:0];

    // State register
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) r_State <= S_IDLE;
        else       r_State <= w_Next;
    end

    // Next-state logic; clear overrides everything
    always_comb begin
        w_Next = r_State;
        if (i_Clr) begin
            w_Next = S_IDLE;
        end else begin
            case (r_State)
                S_IDLE:   if (w_Grant_Add || w_Grant_Sub) w_Next = S_CONV_H;
                S_CONV_H: if (r_Work < 10'd100) w_Next = S_CONV_T;
                S_CONV_T: if (r_Work < 10'd10)  w_Next = S_DONE;
                default:  w_Next = S_IDLE;
            endcase
        end
    end

    // Registered datapath and outputs: score, conversion work, digits, pulses
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_Rr_Sub  <= 1'b0;
            r_Score   <= '0;
            r_Work    <= '0;
            r_H       <= '0;
            r_T       <= '0;
            r_D0      <= '0;
            r_D1      <= '0;
            r_D2      <= '0;
            r_Add_Ack <= 1'b0;
            r_Sub_Ack <= 1'b0;
            r_Busy    <= 1'b0;
            r_Upd     <= 1'b0;
        end else begin
            r_Add_Ack <= 1'b0;
            r_Sub_Ack <= 1'b0;
            r_Upd     <= 1'b0;
            r_Busy    <= (w_Next != S_IDLE);
            if (i_Clr) begin
                r_Score <= '0;
                r_Work  <= '0;
                r_H     <= '0;
                r_T     <= '0;
                r_D0    <= '0;
                r_D1    <= '0;
                r_D2    <= '0;
                r_Upd   <= 1'b1;
            end else begin
                case (r_State)
                    S_IDLE: begin
                        if (w_Grant_Add || w_Grant_Sub) begin
                            r_Score   <= w_Grant_Add ? w_Add_Res : w_Sub_Res;
                            r_Work    <= w_Grant_Add ? w_Add_Res : w_Sub_Res;
                            r_H       <= '0;
                            r_T       <= '0;
                            r_Add_Ack <= w_Grant_Add;
                            r_Sub_Ack <= w_Grant_Sub;
                            // Pointer moves only when both were competing
                            if (i_Add_Req && i_Sub_Req) r_Rr_Sub <= ~r_Rr_Sub;
                        end
                    end
                    S_CONV_H: begin
                        if (r_Work >= 10'd100) begin
                            r_Work <= r_Work - 10'd100;
                            r_H    <= r_H + 4'd1;
                        end
                    end
                    S_CONV_T: begin
                        if (r_Work >= 10'd10) begin
                            r_Work <= r_Work - 10'd10;
                            r_T    <= r_T + 4'd1;
                        end
                    end
                    default: begin
                        r_D2  <= r_H;
                        r_D1  <= r_T;
                        r_D0  <= r_Work[3:0];
                        r_Upd <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign o_Add_Ack = r_Add_Ack;
    assign o_Sub_Ack = r_Sub_Ack;
    assign o_Score   = r_Score;
    assign o_Score0  = r_D0;
    assign o_Score1  = r_D1;
    assign o_Score2  = r_D2;
    assign o_Busy    = r_Busy;
    assign o_Upd     = r_Upd;

endmodule

// File: tb/tb_game_score_ctrl.sv
// Bench for game_score_ctrl. The reference model keeps the score as a plain
// integer. It derives the expected digits and the update latency with integer
// division.
module tb_game_score_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr;
    logic       add_req;
    logic [3:0] add_val;
    logic       sub_req;
    logic [3:0] sub_val;
    logic       add_ack;
    logic       sub_ack;
    logic [9:0] score;
    logic [3:0] d0;
    logic [3:0] d1;
    logic [3:0] d2;
    logic       busy;
    logic       upd;

    int n_asserts = 0;
    int n_fail    = 0;
    int model     = 0;

    game_score_ctrl #(.MAX_SCORE(999), .VAL_W(4)) dut (
        .i_Clk(clk), .i_Rst(rst), .i_Clr(clr),
        .i_Add_Req(add_req), .i_Add_Val(add_val),
        .i_Sub_Req(sub_req), .i_Sub_Val(sub_val),
        .o_Add_Ack(add_ack), .o_Sub_Ack(sub_ack),
        .o_Score(score), .o_Score0(d0), .o_Score1(d1), .o_Score2(d2),
        .o_Busy(busy), .o_Upd(upd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Digits must hold while busy; acks must be single-cycle pulses
    logic [11:0] prev_digits = '0;
    logic        prev_add_ack = 1'b0;
    logic        prev_sub_ack = 1'b0;
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (busy === 1'b1) chk("digits_stable_busy", {d2, d1, d0}, prev_digits);
            if (prev_add_ack)  chk("add_ack_pulse", add_ack, 0);
            if (prev_sub_ack)  chk("sub_ack_pulse", sub_ack, 0);
        end
        prev_digits  = {d2, d1, d0};
        prev_add_ack = add_ack;
        prev_sub_ack = sub_ack;
    end

    function automatic int apply(input int s, input bit is_add, input int v);
        int r;
        r = is_add ? s + v : s - v;
        if (r > 999) r = 999;
        if (r < 0)   r = 0;
        return r;
    endfunction

    function automatic int exp_lat(input int s);
        return 4 + s / 100 + (s % 100) / 10;
    endfunction

    task automatic chk_digits(input string tag);
        chk({tag, "_score"}, score, model);
        chk({tag, "_d2"}, d2, model / 100);
        chk({tag, "_d1"}, d1, (model / 10) % 10);
        chk({tag, "_d0"}, d0, model % 10);
    endtask

    task automatic wait_ack(input bit is_add, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (((is_add ? add_ack : sub_ack) !== 1'b1) && cyc < 40);
    endtask

    task automatic wait_upd(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (upd !== 1'b1 && cyc < 40);
    endtask

    // One request from IDLE: checks ack timing, score, latency and digits
    task automatic do_op(input bit is_add, input int val, input string tag);
        int c;
        int l;
        if (is_add) begin add_req = 1'b1; add_val = 4'(val); end
        else        begin sub_req = 1'b1; sub_val = 4'(val); end
        wait_ack(is_add, c);
        chk({tag, "_ack_cycle"}, c, 1);
        add_req = 1'b0;
        sub_req = 1'b0;
        model = apply(model, is_add, val);
        chk({tag, "_score_at_ack"}, score, model);
        wait_upd(l);
        chk({tag, "_upd_latency"}, l + 1, exp_lat(model));
        chk_digits(tag);
    endtask

    task automatic do_clear(input string tag);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        model = 0;
        chk({tag, "_upd"}, upd, 1);
        chk({tag, "_busy"}, busy, 0);
        chk_digits(tag);
    endtask

    task automatic build(input int target);
        do_clear("build_clr");
        while (model < target)
            do_op(1'b1, (target - model > 15) ? 15 : target - model, "build");
    endtask

    initial begin
        int c;
        int l;
        rst = 1'b1; clr = 1'b0;
        add_req = 1'b0; add_val = '0; sub_req = 1'b0; sub_val = '0;
        repeat (3) @(negedge clk);
        chk("rst_score", score, 0);
        chk("rst_digits", {d2, d1, d0}, 0);
        chk("rst_flags", {add_ack, sub_ack, busy, upd}, 0);
        rst = 1'b0;
        @(negedge clk);

        // add 7: ack at N+1, busy N+1..N+3, update at N+4
        add_req = 1'b1; add_val = 4'd7;
        wait_ack(1'b1, c);
        chk("add7_ack_cycle", c, 1);
        add_req = 1'b0;
        model = 7;
        chk("add7_score", score, 7);
        chk("add7_busy1", {busy, upd}, 2'b10);
        @(negedge clk); chk("add7_busy2", {busy, upd}, 2'b10);
        @(negedge clk); chk("add7_busy3", {busy, upd}, 2'b10);
        @(negedge clk); chk("add7_upd4", {busy, upd}, 2'b01);
        chk_digits("add7");

        // 123 through repeated adds
        for (int i = 0; i < 7; i++) do_op(1'b1, 15, "to123");
        do_op(1'b1, 11, "to123_last");
        chk("d123", {d2, d1, d0}, 12'h123);

        // subtract saturating at zero
        do_clear("clr1");
        do_op(1'b1, 5, "to5");
        do_op(1'b0, 9, "sub9");
        chk("sub9_zero", score, 0);

        // contention: add wins first, then sub on the next IDLE, then sub wins
        for (int r = 0; r < 2; r++) begin
            add_req = 1'b1; add_val = 4'd3; sub_req = 1'b1; sub_val = 4'd2;
            wait_ack(r == 0, c);
            chk("cont_win_cycle", c, 1);
            chk("cont_loser_quiet", (r == 0) ? sub_ack : add_ack, 0);
            if (r == 0) add_req = 1'b0; else sub_req = 1'b0;
            model = apply(model, r == 0, (r == 0) ? 3 : 2);
            chk("cont_win_score", score, model);
            wait_upd(l);
            chk_digits("cont_win");
            @(negedge clk);
            chk("cont_loser_ack", (r == 0) ? sub_ack : add_ack, 1);
            add_req = 1'b0; sub_req = 1'b0;
            model = apply(model, r != 0, (r == 0) ? 2 : 3);
            chk("cont_loser_score", score, model);
            wait_upd(l);
            chk("cont_loser_latency", l + 1, exp_lat(model));
            chk_digits("cont_loser");
        end

        // clear in CONV_H with an add held across it
        build(500);
        add_req = 1'b1; add_val = 4'd4;
        wait_ack(1'b1, c);
        chk("clrmid_ack_cycle", c, 1);
        add_req = 1'b0;
        chk("clrmid_504", score, 504);
        @(negedge clk);
        chk("clrmid_in_conv", busy, 1);
        clr = 1'b1; add_req = 1'b1; add_val = 4'd6;
        @(negedge clk);
        clr = 1'b0;
        model = 0;
        chk("clrmid_upd", upd, 1);
        chk("clrmid_busy", busy, 0);
        chk("clrmid_no_ack", add_ack, 0);
        chk_digits("clrmid");
        @(negedge clk);
        chk("clrmid_held_ack", add_ack, 1);
        add_req = 1'b0;
        model = 6;
        chk("clrmid_held_score", score, 6);
        wait_upd(l);
        chk("clrmid_held_latency", l + 1, exp_lat(6));
        chk_digits("clrmid_held");

        // saturation at 999, maximum latency 22
        build(990);
        do_op(1'b1, 15, "sat999");
        chk("sat999_digits", {d2, d1, d0}, 12'h999);
        chk("sat999_lat", exp_lat(model), 22);

        // zero-valued requests still run a conversion
        do_op(1'b0, 0, "sub0");
        do_op(1'b1, 0, "add0");

        // randomized mix against the model
        for (int i = 0; i < 40; i++)
            do_op($urandom_range(3, 0) != 0, int'($urandom_range(15, 0)), "rand");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
